// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants and types for the Ascon input loader.
//   ASCON_IV       : Ascon-128 initialization vector (state word 0)
//   WORDS_PER_LOAD : 16-bit words per key+nonce load (8 key + 8 nonce)
//   WORD_W / CNT_W : input word width and word counter width
//   load_state_e   : loader FSM states LOAD / START / WAIT
package ascon_pkg;

  localparam logic [63:0] ASCON_IV       = 64'h80400c0600000000;
  localparam int          WORDS_PER_LOAD = 16;
  localparam int          WORD_W         = 16;
  localparam int          CNT_W          = 4;
  localparam int          CAP_W          = WORDS_PER_LOAD * WORD_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } load_state_e;

endpackage

// File: rtl/ascon_input_loader.sv
// ascon_input_loader: collects a 128-bit key and a 128-bit nonce as sixteen
// 16-bit words, then launches the Ascon permutation and waits for it.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   clear        in   synchronous abort back to LOAD, word count 0
//   in_data      in   [15:0] input word
//   in_valid     in   in_data qualifier
//   in_ready     out  high in LOAD; word taken when in_valid && in_ready
//   rounds_done  in   completion pulse from the permutation
//   perm_start   out  one-cycle launch pulse for the permutation
//   S_0_init..S_4_init out [63:0] initial permutation state words
//   busy         out  high while a load or permutation is in progress
module ascon_input_loader
  import ascon_pkg::*;
#(
  parameter logic [63:0] IV = ASCON_IV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rounds_done,
  output logic              perm_start,
  output logic [63:0]       S_0_init,
  output logic [63:0]       S_1_init,
  output logic [63:0]       S_2_init,
  output logic [63:0]       S_3_init,
  output logic [63:0]       S_4_init,
  output logic              busy
);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CAP_W-1:0] cap_q;   // key in [255:128], nonce in [127:0]
  logic             hs;
  logic             last_word;
  logic [7:0]       wr_lsb;

  // clear outranks a handshake in the same cycle
  assign hs        = in_valid && in_ready && !clear;
  assign last_word = (cnt_q == CNT_W'(WORDS_PER_LOAD - 1));
  // word k lands MSB first: lsb = (15-k)*16, i.e. {~k, 4'b0}
  assign wr_lsb    = {~cnt_q, 4'b0000};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and outputs
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    perm_start = 1'b0;
    if (clear) begin
      state_d = LOAD;
    end
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (hs && last_word) state_d = START;
      end
      START: begin
        // a clear in this cycle kills the launch
        perm_start = !clear;
        if (!clear) state_d = WAIT;
      end
      WAIT: begin
        if (rounds_done && !clear) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // word counter: wraps to 0 naturally after word 15
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (hs) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // key/nonce capture: written only on handshakes, kept across clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else if (hs) begin
      cap_q[wr_lsb +: WORD_W] <= in_data;
    end
  end

  assign busy     = (state_q != LOAD) || (cnt_q != '0);
  assign S_0_init = IV;
  assign S_1_init = cap_q[255:192];
  assign S_2_init = cap_q[191:128];
  assign S_3_init = cap_q[127:64];
  assign S_4_init = cap_q[63:0];

endmodule

// File: tb/tb_ascon_input_loader.sv
// tb_ascon_input_loader: table-driven, directed and randomized checks of
// ascon_input_loader against a behavioural reference model.
module tb_ascon_input_loader;

  localparam logic [63:0] IV_C = 64'h80400c0600000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rounds_done;
  logic        perm_start;
  logic [63:0] S_0_init, S_1_init, S_2_init, S_3_init, S_4_init;
  logic        busy;

  ascon_input_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rounds_done(rounds_done),
    .perm_start (perm_start),
    .S_0_init   (S_0_init),
    .S_1_init   (S_1_init),
    .S_2_init   (S_2_init),
    .S_3_init   (S_3_init),
    .S_4_init   (S_4_init),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // reference model: 256-bit key||nonce image, words accepted so far in the
  // current load, and the operation phase (0 loading, 1 launching, 2 running)
  bit [255:0] m_img;
  int         m_cnt;
  int         m_phase;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_img = '0; m_cnt = 0; m_phase = 0;
  endtask

  task automatic mdl_step(input logic v, input logic [15:0] d, input logic rd, input logic clr);
    if (clr) begin
      m_cnt = 0; m_phase = 0;
    end else if (m_phase == 0) begin
      if (v) begin
        m_img[255 - 16*m_cnt -: 16] = d;
        m_cnt = m_cnt + 1;
        if (m_cnt == 16) begin
          m_cnt = 0; m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rd) begin
      m_phase = 0;
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".in_ready"},   64'(in_ready),   64'(m_phase == 0));
    chk({tag, ".perm_start"}, 64'(perm_start), 64'(m_phase == 1));
    chk({tag, ".busy"},       64'(busy),       64'(m_phase != 0 || m_cnt != 0));
    chk({tag, ".S0"}, S_0_init, IV_C);
    chk({tag, ".S1"}, S_1_init, m_img[255:192]);
    chk({tag, ".S2"}, S_2_init, m_img[191:128]);
    chk({tag, ".S3"}, S_3_init, m_img[127:64]);
    chk({tag, ".S4"}, S_4_init, m_img[63:0]);
  endtask

  // drive one cycle; inputs return to idle 1 time unit after the edge
  task automatic cycle(input logic v, input logic [15:0] d, input logic rd, input logic clr);
    in_valid = v; in_data = d; rounds_done = rd; clear = clr;
    @(posedge clk);
    mdl_step(v, d, rd, clr);
    #1;
    in_valid = 1'b0; rounds_done = 1'b0; clear = 1'b0;
  endtask

  function automatic logic [15:0] seq_word(input int k);
    int b;
    b = 2 * (k % 8);
    return {8'(b), 8'(b + 1)};
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rd;
    logic        clr;
    logic        e_rdy;
    logic        e_st;
    logic        e_busy;
  } vec_t;

  vec_t tbl[18];

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; rounds_done = 1'b0;
    mdl_reset();

    // reset state
    #3;
    chk("rst.in_ready",   64'(in_ready),   64'd1);
    chk("rst.perm_start", 64'(perm_start), 64'd0);
    chk("rst.busy",       64'(busy),       64'd0);
    chk("rst.S1",         S_1_init,        64'd0);
    chk("rst.S0",         S_0_init,        IV_C);
    #4 rst_n = 1'b1;

    // back-to-back load of the reference pattern
    for (int k = 0; k < 16; k++)
      tbl[k] = '{1'b1, seq_word(k), 1'b0, 1'b0, (k != 15), (k == 15), 1'b1};
    tbl[16] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rd, tbl[i].clr);
      chk($sformatf("tbl%0d.in_ready", i),   64'(in_ready),   64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d.perm_start", i), 64'(perm_start), 64'(tbl[i].e_st));
      chk($sformatf("tbl%0d.busy", i),       64'(busy),       64'(tbl[i].e_busy));
      if (i == 15) begin
        chk("b2b.S0", S_0_init, IV_C);
        chk("b2b.S1", S_1_init, 64'h0001020304050607);
        chk("b2b.S2", S_2_init, 64'h08090a0b0c0d0e0f);
        chk("b2b.S3", S_3_init, 64'h0001020304050607);
        chk("b2b.S4", S_4_init, 64'h08090a0b0c0d0e0f);
      end
    end

    // same load with in_valid toggling every other cycle
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 16'hDEAD, 1'b0, 1'b0);
      cmp_all("tog.idle");
      cycle(1'b1, seq_word(k), 1'b0, 1'b0);
      if (k < 15) chk("tog.no_start", 64'(perm_start), 64'd0);
    end
    chk("tog.start", 64'(perm_start), 64'd1);
    chk("tog.S1", S_1_init, 64'h0001020304050607);
    chk("tog.S4", S_4_init, 64'h08090a0b0c0d0e0f);

    // in_valid with 0xFFFF ignored while not ready, then rounds_done
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
      cmp_all("wait");
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    chk("wait.ready_after_done", 64'(in_ready), 64'd1);
    chk("wait.S1_kept", S_1_init, 64'h0001020304050607);
    chk("wait.S4_kept", S_4_init, 64'h08090a0b0c0d0e0f);

    // clear after word 5
    for (int k = 0; k < 6; k++) cycle(1'b1, 16'h1111 * 16'(k + 1), 1'b0, 1'b0);
    chk("clr5.busy_before", 64'(busy), 64'd1);
    cycle(1'b0, 16'h0, 1'b0, 1'b1);
    chk("clr5.busy", 64'(busy), 64'd0);
    cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
    chk("clr5.word0", 64'(S_1_init[63:48]), 64'hAAAA);
    cmp_all("clr5");
    cycle(1'b0, 16'h0, 1'b0, 1'b1);

    // clear together with word 15
    for (int k = 0; k < 15; k++) cycle(1'b1, 16'(k * 7 + 3), 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
    chk("clr15.perm_start", 64'(perm_start), 64'd0);
    chk("clr15.in_ready",   64'(in_ready),   64'd1);
    chk("clr15.busy",       64'(busy),       64'd0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    chk("clr15.no_late_start", 64'(perm_start), 64'd0);
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("clr15.word0", 64'(S_1_init[63:48]), 64'h1234);
    cmp_all("clr15");
    cycle(1'b0, 16'h0, 1'b0, 1'b1);

    // asynchronous reset while in WAIT
    for (int k = 0; k < 16; k++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b0, 1'b0);
    chk("arst.in_wait", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("arst.in_ready",   64'(in_ready),   64'd1);
    chk("arst.perm_start", 64'(perm_start), 64'd0);
    chk("arst.busy",       64'(busy),       64'd0);
    chk("arst.S1", S_1_init, 64'd0);
    chk("arst.S2", S_2_init, 64'd0);
    chk("arst.S3", S_3_init, 64'd0);
    chk("arst.S4", S_4_init, 64'd0);
    chk("arst.S0", S_0_init, IV_C);
    #3 rst_n = 1'b1;
    cycle(1'b1, 16'h5A5A, 1'b0, 1'b0);
    chk("arst.word0", 64'(S_1_init[63:48]), 64'h5A5A);
    cmp_all("arst");

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom % 2), 16'($urandom), ($urandom % 6) == 0, ($urandom % 50) == 0);
      cmp_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
